// File: rtl/weight_compensation_scanner_pkg.sv
// Shared sizing and FSM state type for the weight compensation scanner.
// Optional build macro COMP_OVERFLOW_CNT_EN is consumed by the top module.
package weight_compensation_scanner_pkg;

  localparam int unsigned ROWS       = 8;
  localparam int unsigned COLS       = 8;
  localparam int unsigned WEIGHT_W   = 8;
  localparam int unsigned LOW_W      = 4;
  localparam int unsigned MAX_COMP   = 3;
  localparam int unsigned ROW_IDX_W  = $clog2(ROWS);
  localparam int unsigned COL_IDX_W  = $clog2(COLS);
  localparam int unsigned CNT_W      = $clog2(MAX_COMP + 1);
  localparam int unsigned HIGH_W     = WEIGHT_W - LOW_W;
  localparam int unsigned COMP_SLOTS = COLS * MAX_COMP;
  localparam int unsigned OVF_W      = 6;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StColEnd,
    StDone
  } state_e;

endpackage

// File: rtl/weight_compensation_scanner_outlier_detect.sv
// Flags weights outside the signed LOW_W range and splits them into high/low parts.
module weight_compensation_scanner_outlier_detect
  import weight_compensation_scanner_pkg::*;
(
  input  logic [WEIGHT_W-1:0] weight_i,
  output logic                outlier_o,
  output logic [HIGH_W-1:0]   high_o,
  output logic [LOW_W-1:0]    low_o
);

  // The weight fits in LOW_W signed bits only if all bits from the low sign bit up agree.
  logic [WEIGHT_W-LOW_W:0] sign_bits;

  assign sign_bits = weight_i[WEIGHT_W-1:LOW_W-1];
  assign outlier_o = !((&sign_bits) || !(|sign_bits));
  assign high_o    = weight_i[WEIGHT_W-1:LOW_W];
  assign low_o     = weight_i[LOW_W-1:0];

endmodule

// File: rtl/weight_compensation_scanner.sv
// Column-major weight tile scanner emitting low-precision weights and compensation events.
// Define COMP_OVERFLOW_CNT_EN to add the comp_overflow_cnt dropped-outlier counter port.
module weight_compensation_scanner
  import weight_compensation_scanner_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WEIGHT_W-1:0]  weight_data,
  output logic                 out_weight_valid,
  output logic [LOW_W-1:0]     out_weight,
  output logic                 out_Compensation_valid,
  output logic [ROW_IDX_W-1:0] Compensation_Row,
  output logic [HIGH_W-1:0]    Compensation_Value,
  output logic                 change_col,
  output logic                 done
`ifdef COMP_OVERFLOW_CNT_EN
  ,
  output logic [OVF_W-1:0]     comp_overflow_cnt
`endif
);

  state_e                 state_q;
  logic [ROW_IDX_W-1:0]   row_q;
  logic [COL_IDX_W-1:0]   col_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   wvalid_q;
  logic [LOW_W-1:0]       wlow_q;
  logic                   cvalid_q;
  logic [ROW_IDX_W-1:0]   crow_q;
  logic [HIGH_W-1:0]      cval_q;
  logic                   change_col_q;
  logic                   done_q;
`ifdef COMP_OVERFLOW_CNT_EN
  logic [OVF_W-1:0]       ovf_q;
`endif

  logic                   outlier;
  logic [HIGH_W-1:0]      high;
  logic [LOW_W-1:0]       low;
  logic                   accept;

  weight_compensation_scanner_outlier_detect u_outlier_detect (
    .weight_i  (weight_data),
    .outlier_o (outlier),
    .high_o    (high),
    .low_o     (low)
  );

  assign in_ready = (state_q == StScan);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      row_q        <= '0;
      col_q        <= '0;
      cnt_q        <= '0;
      wvalid_q     <= 1'b0;
      wlow_q       <= '0;
      cvalid_q     <= 1'b0;
      crow_q       <= '0;
      cval_q       <= '0;
      change_col_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef COMP_OVERFLOW_CNT_EN
      ovf_q        <= '0;
`endif
    end else begin
      wvalid_q     <= 1'b0;
      cvalid_q     <= 1'b0;
      change_col_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StScan;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef COMP_OVERFLOW_CNT_EN
            ovf_q   <= '0;
`endif
          end
        end
        StScan: begin
          if (accept) begin
            wvalid_q <= 1'b1;
            wlow_q   <= low;
            if (outlier) begin
              if (cnt_q < CNT_W'(MAX_COMP)) begin
                cvalid_q <= 1'b1;
                crow_q   <= row_q;
                cval_q   <= high;
                cnt_q    <= cnt_q + CNT_W'(1);
              end
`ifdef COMP_OVERFLOW_CNT_EN
              else if (ovf_q != '1) begin
                ovf_q <= ovf_q + OVF_W'(1);
              end
`endif
            end
            if (row_q == ROW_IDX_W'(ROWS - 1)) begin
              row_q   <= '0;
              state_q <= StColEnd;
            end else begin
              row_q <= row_q + ROW_IDX_W'(1);
            end
          end
        end
        StColEnd: begin
          // A full column is already slot-aligned downstream, so it needs no pulse.
          change_col_q <= (cnt_q < CNT_W'(MAX_COMP));
          cnt_q        <= '0;
          if (col_q == COL_IDX_W'(COLS - 1)) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            col_q   <= col_q + COL_IDX_W'(1);
            state_q <= StScan;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_weight_valid       = wvalid_q;
  assign out_weight             = wlow_q;
  assign out_Compensation_valid = cvalid_q;
  assign Compensation_Row       = crow_q;
  assign Compensation_Value     = cval_q;
  assign change_col             = change_col_q;
  assign done                   = done_q;
`ifdef COMP_OVERFLOW_CNT_EN
  assign comp_overflow_cnt      = ovf_q;
`endif

endmodule

// File: tb/tb_weight_compensation_scanner.sv
// Directed self-checking bench for weight_compensation_scanner.
module tb_weight_compensation_scanner;

  logic       clk;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] weight_data;
  logic       out_weight_valid;
  logic [3:0] out_weight;
  logic       out_Compensation_valid;
  logic [2:0] Compensation_Row;
  logic [3:0] Compensation_Value;
  logic       change_col;
  logic       done;
`ifdef COMP_OVERFLOW_CNT_EN
  logic [5:0] comp_overflow_cnt;
`endif

  weight_compensation_scanner dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .weight_data            (weight_data),
    .out_weight_valid       (out_weight_valid),
    .out_weight             (out_weight),
    .out_Compensation_valid (out_Compensation_valid),
    .Compensation_Row       (Compensation_Row),
    .Compensation_Value     (Compensation_Value),
    .change_col             (change_col),
    .done                   (done)
`ifdef COMP_OVERFLOW_CNT_EN
    ,
    .comp_overflow_cnt      (comp_overflow_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int overlap = 0;

  logic [7:0] tile [64];
  logic [3:0] wq [$];
  logic [6:0] cq [$];
  int         ccq [$];
  logic [6:0] exp_c [$];
  int         exp_cc [$];

  // Output log, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (out_weight_valid) wq.push_back(out_weight);
      if (out_Compensation_valid) cq.push_back({Compensation_Row, Compensation_Value});
      if (change_col) ccq.push_back(wq.size() / 8 - 1);
      if (out_Compensation_valid && change_col) overlap++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wq.delete();
    cq.delete();
    ccq.delete();
    overlap = 0;
  endtask

  // Fill with in-range weights; optionally plant the column 0 and column 3 outliers.
  task automatic build_tile(input bit with_outliers);
    for (int i = 0; i < 64; i++) begin
      logic [3:0] n;
      n = 4'(i * 5 + 3);
      tile[i] = {{4{n[3]}}, n};
    end
    if (with_outliers) begin
      tile[2]  = 8'h7F;
      tile[5]  = 8'h80;
      tile[24] = 8'h10;
      tile[25] = 8'h20;
      tile[26] = 8'h30;
      tile[28] = 8'h40;
      tile[30] = 8'h50;
    end
  endtask

  // Called at a negedge; returns at the negedge after the weight is accepted.
  task automatic feed(input logic [7:0] w);
    int t;
    t = 0;
    in_valid    = 1'b1;
    weight_data = w;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("feed_ready_timeout", 32'(t < 20), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic feed_cols(input int first_idx, input int n, input bit gap);
    for (int i = first_idx; i < first_idx + n; i++) begin
      if (gap) @(negedge clk);
      feed(tile[i]);
      if (i % 8 == 7) chk("col_end_in_ready", 32'(in_ready), 32'd0);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", 32'(t < 50), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_tile(input string tag);
    chk({tag, "_weight_beats"}, 32'(wq.size()), 32'd64);
    for (int i = 0; i < 64; i++)
      if (i < wq.size()) chk({tag, "_out_weight"}, 32'(wq[i]), 32'(tile[i][3:0]));
    chk({tag, "_comp_count"}, 32'(cq.size()), 32'(exp_c.size()));
    for (int i = 0; i < exp_c.size(); i++)
      if (i < cq.size()) chk({tag, "_comp_event"}, 32'(cq[i]), 32'(exp_c[i]));
    chk({tag, "_change_col_count"}, 32'(ccq.size()), 32'(exp_cc.size()));
    for (int i = 0; i < exp_cc.size(); i++)
      if (i < ccq.size()) chk({tag, "_change_col_column"}, 32'(ccq[i]), 32'(exp_cc[i]));
    chk({tag, "_comp_change_col_overlap"}, 32'(overlap), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_done_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {19'd0, in_ready, out_weight_valid, out_weight, out_Compensation_valid,
              Compensation_Row, Compensation_Value, change_col, done}, 32'd0);
`ifdef COMP_OVERFLOW_CNT_EN
    chk({tag, "_ovf"}, 32'(comp_overflow_cnt), 32'd0);
`endif
  endtask

  task automatic set_expect_a();
    exp_c  = '{7'h27, 7'h58, 7'h01, 7'h12, 7'h23};
    exp_cc = '{0, 1, 2, 4, 5, 6, 7};
  endtask

  initial begin
    rst         = 1'b0;
    start       = 1'b0;
    in_valid    = 1'b0;
    weight_data = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("idle_outputs");

    // Tile A: outliers in columns 0 and 3, start pulsed mid-scan.
    build_tile(1'b1);
    set_expect_a();
    clear_log();
    pulse_start();
    chk("scan_in_ready", 32'(in_ready), 32'd1);
    feed_cols(0, 11, 1'b0);
    pulse_start();
    feed_cols(11, 53, 1'b0);
    wait_done();
    check_tile("tile_a");
`ifdef COMP_OVERFLOW_CNT_EN
    chk("tile_a_overflow_cnt", 32'(comp_overflow_cnt), 32'd2);
`endif

    // Tile B: no outliers, in_valid every other cycle, started from DONE.
    build_tile(1'b0);
    exp_c.delete();
    exp_cc = '{0, 1, 2, 3, 4, 5, 6, 7};
    clear_log();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_done_falls", 32'(done), 32'd0);
    chk("restart_in_ready", 32'(in_ready), 32'd1);
    feed_cols(0, 64, 1'b1);
    wait_done();
    check_tile("tile_b");
`ifdef COMP_OVERFLOW_CNT_EN
    chk("tile_b_overflow_cnt", 32'(comp_overflow_cnt), 32'd0);
`endif

    // Tile C: reset in the middle of column 4, then a full rescan of tile A.
    build_tile(1'b1);
    clear_log();
    pulse_start();
    feed_cols(0, 34, 1'b0);
    #2 rst = 1'b0;
    #1 check_all_zero("mid_tile_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset_idle");
    set_expect_a();
    clear_log();
    pulse_start();
    feed_cols(0, 64, 1'b0);
    wait_done();
    check_tile("tile_c");
`ifdef COMP_OVERFLOW_CNT_EN
    chk("tile_c_overflow_cnt", 32'(comp_overflow_cnt), 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_compensation_scanner.md
Name: weight_compensation_scanner

Overview:
- Upstream neighbour of the activation-side compensation-row recorder.
- Streams an 8x8 weight tile column by column, one weight per cycle.
- Splits each weight into a low-precision part and flags outlier rows that need compensation.
- Emits per column up to MAX_COMP compensation events (row index + high nibble), a change_col pulse at column end, and done after the last column.

Parameters:
- ROWS, 8, rows per column; row index width = clog2(ROWS) = 3
- COLS, 8, columns per tile
- WEIGHT_W, 8, input weight width (signed)
- LOW_W, 4, low-precision weight width (signed)
- MAX_COMP, 3, compensation slots per column

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  begin tile scan; honoured only in IDLE or DONE
- in_valid  in  1  weight_data valid
- in_ready  out  1  scanner accepts weight this cycle
- weight_data  in  WEIGHT_W  signed weight; column-major order, row 0 first
- out_weight_valid  out  1  out_weight valid
- out_weight  out  LOW_W  weight_data[LOW_W-1:0]
- out_Compensation_valid  out  1  compensation event
- Compensation_Row  out  3  row index of the outlier
- Compensation_Value  out  WEIGHT_W-LOW_W  weight_data[7:4] of the outlier
- change_col  out  1  one-cycle column-end pulse
- done  out  1  tile complete (level)

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, row/col/count counters 0. Reset mid-tile abandons the tile; no resume.
- Outlier condition: weight_data[7:3] not all equal (value outside the signed 4-bit range).
- FSM IDLE -> SCAN on start.
  - SCAN: in_ready=1. Each accepted weight (in_valid&in_ready) registers out_weight_valid/out_weight next cycle, 1-cycle latency.
  - If the weight is an outlier and count<MAX_COMP: out_Compensation_valid=1 next cycle with Compensation_Row=row and Compensation_Value; count++.
  - Outliers beyond MAX_COMP in a column are dropped, with no compensation output.
  - row++ per accept; on row==ROWS-1 accept -> COL_END.
- COL_END (1 cycle): in_ready=0. change_col is registered next cycle iff count<MAX_COMP.
  - The consumer pads its slot index to the next multiple of 3; a full column (count==MAX_COMP) is already aligned, so no pulse is sent.
  - This also means the last comp event and change_col are never asserted in the same cycle.
  - count<-0, col++; if col==COLS-1 -> DONE, else -> SCAN.
- DONE: done=1 held, in_ready=0. start -> clear counters, done falls the next cycle, -> SCAN.
- start in SCAN/COL_END is ignored.
- in_valid=0 stalls: the row counter holds and no outputs are produced.
- All outputs are registered; pulses last exactly one cycle.
- Tile output totals: 64 out_weight beats; comp events <= COLS*MAX_COMP = 24.

Optional Feature:
- Macro COMP_OVERFLOW_CNT_EN.
- Defined: adds output comp_overflow_cnt [5:0], the count of dropped outliers in the current tile. It saturates at 63, clears on start and on reset, and is valid while done=1.
- Undefined: port and logic absent; dropped outliers are silently discarded.

Decomposition:
- Shared package holds ROWS, COLS, WEIGHT_W, LOW_W, MAX_COMP, the derived ROW_IDX_W=3 and COMP_SLOTS=24, and the FSM state enum (IDLE, SCAN, COL_END, DONE).
- One natural sub-module: outlier_detect, a combinational outlier flag plus high/low nibble split.

Test Plan:
- No outliers: 64 weights all in [-8,7] -> 8 change_col pulses, 0 comp events, done after 8th COL_END.
- Column 0 weights 0x7F at row 2 and 0x80 at row 5 -> comp events (row 2, value 0x7) then (row 5, value 0x8); change_col pulse for column 0.
- Column 3 with 5 outliers at rows 0,1,2,4,6 -> events for rows 0,1,2 only; no change_col for column 3. With COMP_OVERFLOW_CNT_EN, comp_overflow_cnt=2 at done.
- in_valid toggled every other cycle -> identical output sequence, only stretched in time; in_ready low in every COL_END cycle.
- Reset asserted mid-column 4 -> all outputs 0 immediately. A new start then rescans from row 0, col 0.
- start pulsed during SCAN -> ignored. start in DONE -> done falls the next cycle and a new tile is scanned.
